// File: rtl/matriz_pkg.sv
// Shared constants, FSM state encoding and slice helper for the matrix
// element-stream transmitter.
package matriz_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int N_ELEM = DIM * DIM;
  localparam int MAT_W  = N_ELEM * ELEM_W;
  localparam int K_W    = 5;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    ENVIA   = 2'd2,
    FIM     = 2'd3
  } estado_t;

  // Bit offset of element k inside the packed matrix.
  function automatic logic [7:0] elem_offset(input logic [K_W-1:0] k);
    return 8'(k) * 8'(ELEM_W);
  endfunction

endpackage

// File: rtl/contador_linha_coluna.sv
// Row/column position counter in row-major order, with a registered flag
// marking the final element of the matrix.
module contador_linha_coluna
  import matriz_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] linha,
  output logic [2:0] coluna,
  output logic       ultimo
);

  logic [2:0] linha_prox_s;
  logic [2:0] coluna_prox_s;

  // Next position: column wraps at DIM-1 and carries into the row.
  always_comb begin
    linha_prox_s  = linha;
    coluna_prox_s = coluna;
    if (coluna == 3'(DIM - 1)) begin
      coluna_prox_s = 3'd0;
      if (linha == 3'(DIM - 1)) begin
        linha_prox_s = 3'd0;
      end else begin
        linha_prox_s = linha + 3'd1;
      end
    end else begin
      coluna_prox_s = coluna + 3'd1;
    end
  end

  // Position and last-element flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      linha  <= 3'd0;
      coluna <= 3'd0;
      ultimo <= 1'b0;
    end else if (clear) begin
      linha  <= 3'd0;
      coluna <= 3'd0;
      ultimo <= 1'b0;
    end else if (enable) begin
      linha  <= linha_prox_s;
      coluna <= coluna_prox_s;
      ultimo <= (linha_prox_s == 3'(DIM - 1)) && (coluna_prox_s == 3'(DIM - 1));
    end else begin
      linha  <= linha;
      coluna <= coluna;
      ultimo <= ultimo;
    end
  end

endmodule

// File: rtl/transmissor_matriz.sv
// Latches a packed 5x5 signed byte matrix on start and streams it out one
// element per valid/ready handshake in row-major order.
module transmissor_matriz
  import matriz_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MAT_W-1:0]  matriz_in,
  output logic [ELEM_W-1:0] elemento,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [2:0]        linha,
  output logic [2:0]        coluna,
  output logic              ultimo,
  output logic              busy,
  output logic              done
);

  estado_t          estado_r;
  logic [MAT_W-1:0] buffer_r;
  logic [K_W-1:0]   k_r;
  logic [K_W-1:0]   prox_k_s;
  logic             transf_s;
  logic             ultima_transf_s;
  logic             aceita_start_s;
  logic             cont_clear_s;
  logic             cont_enable_s;

  assign prox_k_s        = k_r + 5'd1;
  assign transf_s        = (estado_r == ENVIA) && elem_valid && elem_ready;
  assign ultima_transf_s = transf_s && (k_r == 5'(N_ELEM - 1));
  assign aceita_start_s  = (estado_r == OCIOSO) && start;
  // Position counter restarts on a new matrix and after the final element.
  assign cont_clear_s    = aceita_start_s || ultima_transf_s;
  assign cont_enable_s   = transf_s && !ultima_transf_s;

  contador_linha_coluna u_contador (
    .clk    (clk),
    .reset  (reset),
    .clear  (cont_clear_s),
    .enable (cont_enable_s),
    .linha  (linha),
    .coluna (coluna),
    .ultimo (ultimo)
  );

  // Transmit FSM with buffer, index and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_r   <= OCIOSO;
      buffer_r   <= '0;
      k_r        <= 5'd0;
      elemento   <= 8'd0;
      elem_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          done       <= 1'b0;
          elem_valid <= 1'b0;
          if (start) begin
            buffer_r <= matriz_in;
            k_r      <= 5'd0;
            busy     <= 1'b1;
            estado_r <= CARREGA;
          end else begin
            busy <= 1'b0;
          end
        end
        CARREGA: begin
          elemento   <= buffer_r[elem_offset(k_r) +: ELEM_W];
          elem_valid <= 1'b1;
          estado_r   <= ENVIA;
        end
        ENVIA: begin
          if (ultima_transf_s) begin
            elem_valid <= 1'b0;
            elemento   <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b1;
            estado_r   <= FIM;
          end else if (transf_s) begin
            k_r      <= prox_k_s;
            elemento <= buffer_r[elem_offset(prox_k_s) +: ELEM_W];
          end else begin
            k_r <= k_r;
          end
        end
        FIM: begin
          done     <= 1'b0;
          estado_r <= OCIOSO;
        end
        default: begin
          elem_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          estado_r   <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_matriz.sv
// Scoreboard bench for transmissor_matriz: expected elements are queued at
// start and compared whenever the DUT offers an element.
module tb_transmissor_matriz;

  logic         clk;
  logic         reset;
  logic         start;
  logic [199:0] matriz_in;
  logic [7:0]   elemento;
  logic         elem_valid;
  logic         elem_ready;
  logic [2:0]   linha;
  logic [2:0]   coluna;
  logic         ultimo;
  logic         busy;
  logic         done;

  typedef struct {
    logic [7:0] e;
    logic [2:0] l;
    logic [2:0] c;
    logic       u;
  } exp_t;

  exp_t         q[$];
  int           n_assert;
  int           n_fail;
  logic         pend_done;
  logic [199:0] m_inc;
  logic [199:0] m_sig;
  logic [199:0] m_alt;
  int           t_out;

  transmissor_matriz dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .matriz_in  (matriz_in),
    .elemento   (elemento),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .linha      (linha),
    .coluna     (coluna),
    .ultimo     (ultimo),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_matrix(input logic [199:0] m);
    for (int k = 0; k < 25; k++) begin
      exp_t x;
      x.e = m[k*8 +: 8];
      x.l = 3'(k / 5);
      x.c = 3'(k % 5);
      x.u = (k == 24);
      q.push_back(x);
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs against the scoreboard.
  task automatic tick(input logic rdy, input logic st);
    @(negedge clk);
    elem_ready = rdy;
    start      = st;
    chk("done", done, pend_done);
    pend_done = 1'b0;
    if (elem_valid) begin
      if (q.size() == 0) begin
        chk("valid_without_data", elem_valid, 1'b0);
      end else begin
        chk("elemento", elemento, q[0].e);
        chk("linha", linha, q[0].l);
        chk("coluna", coluna, q[0].c);
        chk("ultimo", ultimo, q[0].u);
        if (rdy) begin
          pend_done = q[0].u;
          void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_elemento"}, elemento, 8'd0);
    chk({tag, "_valid"}, elem_valid, 1'b0);
    chk({tag, "_linha"}, linha, 3'd0);
    chk({tag, "_coluna"}, coluna, 3'd0);
    chk({tag, "_ultimo"}, ultimo, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Start pulse in OCIOSO followed by the CARREGA cycle.
  task automatic begin_stream(input logic [199:0] m);
    matriz_in = m;
    push_matrix(m);
    tick(1'b0, 1'b1);
    chk("idle_busy", busy, 1'b0);
    tick(1'b1, 1'b0);
    chk("carrega_busy", busy, 1'b1);
    chk("carrega_valid", elem_valid, 1'b0);
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating.
  task automatic drain(input int pat, input int budget, output int t);
    t = 0;
    while (q.size() > 0 && t < budget) begin
      tick((pat == 0) ? 1'b1 : ((t % 3) == 0), 1'b0);
      t++;
    end
    chk("drain_timeout", q.size(), 0);
    tick(1'b0, 1'b0);
    chk("fim_busy", busy, 1'b0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    pend_done  = 1'b0;
    reset      = 1'b0;
    start      = 1'b0;
    elem_ready = 1'b0;
    matriz_in  = '0;
    m_inc      = '0;
    m_sig      = '0;
    m_alt      = '0;
    for (int k = 0; k < 25; k++) begin
      m_inc[k*8 +: 8] = 8'(k + 1);
      m_alt[k*8 +: 8] = 8'(8'hA0 + k);
    end
    m_sig[0*8 +: 8]  = 8'h80;
    m_sig[12*8 +: 8] = 8'h7F;
    m_sig[24*8 +: 8] = 8'hFF;

    // Reset state
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    chk_zero("after_reset");

    // Full throughput: 25 elements in 25 consecutive cycles
    begin_stream(m_inc);
    drain(0, 100, t_out);
    chk("throughput_cycles", t_out, 25);

    // Back-to-back start on the cycle after done, signed extremes
    begin_stream(m_sig);
    drain(0, 100, t_out);
    chk("b2b_cycles", t_out, 25);

    // Backpressure
    matriz_in = m_alt;
    tick(1'b0, 1'b0);
    begin_stream(m_alt);
    drain(1, 200, t_out);
    chk("bp_cycles", t_out, 73);

    // Reset mid-stream at k=7
    begin_stream(m_inc);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
    chk("pre_reset_remaining", q.size(), 18);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_zero("midreset1");
    tick(1'b0, 1'b0);
    chk_zero("midreset2");
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    tick(1'b0, 1'b0);
    chk_zero("post_midreset");
    begin_stream(m_sig);
    drain(0, 100, t_out);
    chk("restart_cycles", t_out, 25);

    // Start while busy plus matriz_in changes mid-stream
    tick(1'b0, 1'b0);
    begin_stream(m_inc);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    matriz_in = m_alt;
    tick(1'b1, 1'b1);
    matriz_in = m_sig;
    drain(0, 100, t_out);
    tick(1'b0, 1'b0);
    chk("no_queued_start_busy", busy, 1'b0);
    tick(1'b0, 1'b0);
    chk("no_queued_start_valid", elem_valid, 1'b0);
    tick(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
